// File: rtl/ni_pkg.sv
// +----------------------------------------------------------------------------+
// | ni_pkg : shared state encodings and flit-format helpers for ni_param       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package ni_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HEAD = 2'd1,
        TX_BODY = 2'd2,
        TX_TAIL = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_HEAD = 2'd0,
        RX_BODY = 2'd1,
        RX_TAIL = 2'd2
    } rx_state_e;

    function automatic int nb_of(input int data_w, input int flit_w);
        return data_w / flit_w;
    endfunction

    function automatic int cnt_w_of(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    // Low w bits set; a shift by 64 wraps to zero so w=64 still yields all ones.
    function automatic logic [63:0] ones_of(input int w);
        return (64'(1) << w) - 64'(1);
    endfunction

    function automatic logic [63:0] head_marker(input int flit_w, input int addr_w);
        return ones_of(flit_w) & ~ones_of(addr_w);
    endfunction

    function automatic logic [63:0] tail_const(input int flit_w);
        return ones_of(flit_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ni_fifo.sv
// +----------------------------------------------------------------------------+
// | ni_fifo : first-word fall-through FIFO for received words                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ni_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/ni_param.sv
// +----------------------------------------------------------------------------+
// | ni_param : NoC network interface, word port <-> head/body/tail flits       |
// | Optional tail checksum enabled by defining NI_CHECKSUM_EN.                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ni_param
    import ni_pkg::*;
#(
    parameter int FLIT_W     = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 2,
    parameter int LOCAL_ADDR = 0,
    parameter int RX_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [ADDR_W-1:0] tx_dest,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_out_valid,
    input  logic              flit_out_ready,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_in_valid,
    output logic              flit_in_ready,
    output logic              rx_err,
    output logic              rx_misroute
);

    localparam int                NB        = nb_of(DATA_W, FLIT_W);
    localparam int                CNT_W     = cnt_w_of(NB);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NB - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [FLIT_W-1:0] HEAD_MARK = FLIT_W'(head_marker(FLIT_W, ADDR_W));
    localparam logic [ADDR_W-1:0] LOCAL_C   = ADDR_W'(LOCAL_ADDR);
`ifndef NI_CHECKSUM_EN
    localparam logic [FLIT_W-1:0] TAIL_ONES = FLIT_W'(tail_const(FLIT_W));
`endif

    // ---------------------------------------------------------------- TX path
    tx_state_e         tx_state_q, tx_state_d;
    logic [DATA_W-1:0] tx_word_q,  tx_word_d;
    logic [ADDR_W-1:0] tx_dest_q,  tx_dest_d;
    logic [CNT_W-1:0]  tx_cnt_q,   tx_cnt_d;
    logic [FLIT_W-1:0] tx_body;
    logic [FLIT_W-1:0] tx_tail;

    always_comb begin
        tx_body = '0;
        for (int i = 0; i < NB; i++) begin
            if (tx_cnt_q == CNT_W'(i)) tx_body = tx_word_q[DATA_W-1-i*FLIT_W -: FLIT_W];
        end
    end

`ifdef NI_CHECKSUM_EN
    always_comb begin
        tx_tail = '0;
        for (int i = 0; i < NB; i++) begin
            tx_tail = tx_tail ^ tx_word_q[i*FLIT_W +: FLIT_W];
        end
    end
`else
    assign tx_tail = TAIL_ONES;
`endif

    // Outputs come only from held state, so a stalled flit stays stable.
    always_comb begin
        tx_state_d     = tx_state_q;
        tx_word_d      = tx_word_q;
        tx_dest_d      = tx_dest_q;
        tx_cnt_d       = tx_cnt_q;
        tx_ready       = 1'b0;
        flit_out_valid = 1'b0;
        flit_out       = '0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    tx_word_d  = tx_data;
                    tx_dest_d  = tx_dest;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_HEAD;
                end
            end
            TX_HEAD: begin
                flit_out_valid = 1'b1;
                flit_out       = HEAD_MARK | FLIT_W'(tx_dest_q);
                if (flit_out_ready) tx_state_d = TX_BODY;
            end
            TX_BODY: begin
                flit_out_valid = 1'b1;
                flit_out       = tx_body;
                if (flit_out_ready) begin
                    if (tx_cnt_q == CNT_LAST) tx_state_d = TX_TAIL;
                    else                      tx_cnt_d   = tx_cnt_q + CNT_ONE;
                end
            end
            TX_TAIL: begin
                flit_out_valid = 1'b1;
                flit_out       = tx_tail;
                if (flit_out_ready) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_word_q  <= '0;
            tx_dest_q  <= '0;
            tx_cnt_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_word_q  <= tx_word_d;
            tx_dest_q  <= tx_dest_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    // ---------------------------------------------------------------- RX path
    rx_state_e         rx_state_q, rx_state_d;
    logic [DATA_W-1:0] rx_word_q,  rx_word_d;
    logic [CNT_W-1:0]  rx_cnt_q,   rx_cnt_d;
    logic              rx_drop_q,  rx_drop_d;
    logic              rx_err_q,   rx_err_d;
    logic              rx_mis_q,   rx_mis_d;
    logic              rx_accept;
    logic              rx_tail_ok;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;

    // Heads wait for a free slot, so the eventual tail push never meets a full FIFO.
    assign flit_in_ready = !((rx_state_q == RX_HEAD) && fifo_full);
    assign rx_accept     = flit_in_valid && flit_in_ready;

`ifdef NI_CHECKSUM_EN
    logic [FLIT_W-1:0] rx_csum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_csum_q <= '0;
        end else if (rx_accept) begin
            if (rx_state_q == RX_HEAD)      rx_csum_q <= '0;
            else if (rx_state_q == RX_BODY) rx_csum_q <= rx_csum_q ^ flit_in;
        end
    end

    assign rx_tail_ok = (flit_in == rx_csum_q);
`else
    assign rx_tail_ok = (flit_in == TAIL_ONES);
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_word_d  = rx_word_q;
        rx_cnt_d   = rx_cnt_q;
        rx_drop_d  = rx_drop_q;
        rx_err_d   = 1'b0;
        rx_mis_d   = 1'b0;
        fifo_push  = 1'b0;
        case (rx_state_q)
            RX_HEAD: begin
                if (rx_accept) begin
                    if ((flit_in & HEAD_MARK) != HEAD_MARK) begin
                        rx_err_d = 1'b1;
                    end else begin
                        rx_drop_d  = (flit_in[ADDR_W-1:0] != LOCAL_C);
                        rx_mis_d   = (flit_in[ADDR_W-1:0] != LOCAL_C);
                        rx_cnt_d   = '0;
                        rx_state_d = RX_BODY;
                    end
                end
            end
            RX_BODY: begin
                if (rx_accept) begin
                    rx_word_d = DATA_W'({rx_word_q, flit_in});
                    if (rx_cnt_q == CNT_LAST) rx_state_d = RX_TAIL;
                    else                      rx_cnt_d   = rx_cnt_q + CNT_ONE;
                end
            end
            RX_TAIL: begin
                if (rx_accept) begin
                    rx_state_d = RX_HEAD;
                    if (!rx_drop_q) begin
                        if (rx_tail_ok) fifo_push = 1'b1;
                        else            rx_err_d  = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_HEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RX_HEAD;
            rx_word_q  <= '0;
            rx_cnt_q   <= '0;
            rx_drop_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_mis_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_word_q  <= rx_word_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_drop_q  <= rx_drop_d;
            rx_err_q   <= rx_err_d;
            rx_mis_q   <= rx_mis_d;
        end
    end

    assign rx_err      = rx_err_q;
    assign rx_misroute = rx_mis_q;
    assign rx_valid    = !fifo_empty;

    ni_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (DATA_W)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  (rx_word_d),
        .pop_i   (rx_valid && rx_ready),
        .data_o  (rx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_ni_param.sv
// +----------------------------------------------------------------------------+
// | tb_ni_param : randomized + directed self-checking bench for ni_param       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ni_param;

    localparam int         FLIT_W   = 8;
    localparam int         DATA_W   = 32;
    localparam int         ADDR_W   = 2;
    localparam int         RX_DEPTH = 4;
    localparam int         NB       = 4;
    localparam logic [1:0] LOCAL_A  = 2'd1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] tx_data;
    logic [ADDR_W-1:0] tx_dest;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [FLIT_W-1:0] flit_out;
    logic              flit_out_valid;
    logic              flit_out_ready;
    logic [FLIT_W-1:0] flit_in;
    logic              flit_in_valid;
    logic              flit_in_ready;
    logic              rx_err;
    logic              rx_misroute;

    ni_param #(
        .FLIT_W     (FLIT_W),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .LOCAL_ADDR (1),
        .RX_DEPTH   (RX_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_data        (tx_data),
        .tx_dest        (tx_dest),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .flit_out       (flit_out),
        .flit_out_valid (flit_out_valid),
        .flit_out_ready (flit_out_ready),
        .flit_in        (flit_in),
        .flit_in_valid  (flit_in_valid),
        .flit_in_ready  (flit_in_ready),
        .rx_err         (rx_err),
        .rx_misroute    (rx_misroute)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_tx[$];   // flits still owed on flit_out, head of queue is current
    logic [31:0] exp_rx[$];  // words the processor should see, in order
    logic [7:0] cur_pkt[$];  // flits of the packet currently arriving on flit_in
    int         fo_mode = 0; // 0: always ready, 1: toggle, 2: random
    int         rr_mode = 0; // 0: caller drives rx_ready, 2: random
    logic       tx_acc;
    logic       rx_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tail_of(input logic [31:0] w);
`ifdef NI_CHECKSUM_EN
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`else
        return 8'hFF;
`endif
    endfunction

    // Packet-level receive rules; returns {expect rx_err, expect rx_misroute}.
    function automatic logic [1:0] rx_model(input logic [7:0] f);
        logic [7:0]  h;
        logic [31:0] w;
        logic [1:0]  r;
        r = 2'b00;
        if (cur_pkt.size() == 0) begin
            if (f[7:2] != 6'h3F) begin
                r[1] = 1'b1;
            end else begin
                cur_pkt.push_back(f);
                if (f[1:0] != LOCAL_A) r[0] = 1'b1;
            end
        end else begin
            cur_pkt.push_back(f);
            if (cur_pkt.size() == NB + 2) begin
                h = cur_pkt[0];
                w = {cur_pkt[1], cur_pkt[2], cur_pkt[3], cur_pkt[4]};
                if (h[1:0] == LOCAL_A) begin
                    if (f == tail_of(w)) exp_rx.push_back(w);
                    else                 r[1] = 1'b1;
                end
                cur_pkt.delete();
            end
        end
        return r;
    endfunction

    // One clock: note handshakes, advance the model across the edge, compare all outputs.
    task automatic tick();
        logic        in_rst, pop, fo_hs;
        logic [31:0] d;
        logic [1:0]  a;
        logic [7:0]  f;
        logic [1:0]  ev;
        in_rst = !rst_n;
        tx_acc = tx_valid && tx_ready && !in_rst;
        rx_acc = flit_in_valid && flit_in_ready && !in_rst;
        pop    = rx_valid && rx_ready && !in_rst;
        fo_hs  = flit_out_valid && flit_out_ready && !in_rst;
        d = tx_data;
        a = tx_dest;
        f = flit_in;
        ev = 2'b00;
        @(negedge clk);
        if (in_rst) begin
            exp_tx.delete();
            exp_rx.delete();
            cur_pkt.delete();
        end else begin
            if (fo_hs) void'(exp_tx.pop_front());
            if (tx_acc) begin
                exp_tx.push_back({6'h3F, a});
                for (int i = 0; i < NB; i++) exp_tx.push_back(d[31-8*i -: 8]);
                exp_tx.push_back(tail_of(d));
            end
            if (pop) void'(exp_rx.pop_front());
            if (rx_acc) ev = rx_model(f);
        end
        check("tx_ready", 32'(tx_ready), 32'(exp_tx.size() == 0));
        check("flit_out_valid", 32'(flit_out_valid), 32'(exp_tx.size() != 0));
        if (exp_tx.size() != 0) check("flit_out", 32'(flit_out), 32'(exp_tx[0]));
        check("rx_valid", 32'(rx_valid), 32'(exp_rx.size() != 0));
        if (exp_rx.size() != 0) check("rx_data", rx_data, exp_rx[0]);
        check("flit_in_ready", 32'(flit_in_ready),
              32'(!(cur_pkt.size() == 0 && exp_rx.size() == RX_DEPTH)));
        check("rx_err", 32'(rx_err), 32'(ev[1]));
        check("rx_misroute", 32'(rx_misroute), 32'(ev[0]));
        if (fo_mode == 0)      flit_out_ready = 1'b1;
        else if (fo_mode == 1) flit_out_ready = ~flit_out_ready;
        else                   flit_out_ready = 1'($urandom_range(0, 1));
        if (rr_mode == 2)      rx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_tx(input logic [31:0] d, input logic [1:0] a);
        tx_data  = d;
        tx_dest  = a;
        tx_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (tx_acc) break;
        end
        check("tx_accept", 32'(tx_acc), 32'd1);
        tx_valid = 1'b0;
    endtask

    task automatic put_flit(input logic [7:0] f);
        flit_in       = f;
        flit_in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (rx_acc) break;
        end
        check("flit_in_accept", 32'(rx_acc), 32'd1);
        flit_in_valid = 1'b0;
    endtask

    task automatic send_rx_pkt(input logic [31:0] d, input logic [1:0] a, input logic [7:0] corrupt);
        put_flit({6'h3F, a});
        for (int i = 0; i < NB; i++) put_flit(d[31-8*i -: 8]);
        put_flit(tail_of(d) ^ corrupt);
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (exp_tx.size() == 0 && exp_rx.size() == 0) break;
            tick();
        end
        check("drain", 32'(exp_tx.size() + exp_rx.size()), 32'd0);
    endtask

    initial begin
        logic [7:0]  t1 [6];
        logic [31:0] w;
        logic [1:0]  a;
        int          kind;

        rst_n          = 1'b0;
        tx_data        = '0;
        tx_dest        = '0;
        tx_valid       = 1'b0;
        rx_ready       = 1'b1;
        flit_out_ready = 1'b1;
        flit_in        = '0;
        flit_in_valid  = 1'b0;

        tick();
        check("reset_flit_out", 32'(flit_out), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fixed packet, router always ready: exact flit sequence back to back.
        t1[0] = 8'hFF; t1[1] = 8'hDE; t1[2] = 8'hAD;
        t1[3] = 8'hBE; t1[4] = 8'hEF; t1[5] = tail_of(32'hDEADBEEF);
        send_tx(32'hDEADBEEF, 2'd3);
        for (int i = 0; i < 6; i++) begin
            check("t1_flit", 32'(flit_out), 32'(t1[i]));
            tick();
        end
        check("t1_idle", 32'(flit_out_valid), 32'd0);

        // Router stalls every other cycle; two packets back to back.
        fo_mode = 1;
        send_tx($urandom(), 2'($urandom_range(0, 3)));
        send_tx($urandom(), 2'($urandom_range(0, 3)));
        drain();
        fo_mode = 0;

        // Known inbound packet lands in the FIFO the cycle after its tail.
        rx_ready = 1'b0;
        send_rx_pkt(32'h12345678, LOCAL_A, 8'h00);
        check("t3_rx_valid", 32'(rx_valid), 32'd1);
        check("t3_rx_data", rx_data, 32'h12345678);

        // Fill the FIFO, see the fifth head blocked, then release.
        rx_ready = 1'b1;
        drain();
        rx_ready = 1'b0;
        for (int p = 0; p < 4; p++) send_rx_pkt($urandom(), LOCAL_A, 8'h00);
        flit_in       = {6'h3F, LOCAL_A};
        flit_in_valid = 1'b1;
        tick();
        check("t4_head_blocked", 32'(flit_in_ready), 32'd0);
        rx_ready = 1'b1;
        send_rx_pkt($urandom(), LOCAL_A, 8'h00);
        drain();

        // Bad marker, misrouted packet, corrupted tail.
        put_flit(8'h7D);
        check("t5_bad_head", 32'(rx_err), 32'd1);
        put_flit(8'hFE);
        check("t5_misroute", 32'(rx_misroute), 32'd1);
        for (int i = 0; i < NB; i++) put_flit(8'($urandom()));
        put_flit(8'hFF);
        check("t5_no_push", 32'(rx_valid), 32'd0);
        send_rx_pkt($urandom(), LOCAL_A, 8'h5A);
        check("t5_bad_tail", 32'(rx_err), 32'd1);
        check("t5_bad_tail_no_push", 32'(rx_valid), 32'd0);

        // Reset in the middle of a TX and an RX packet.
        rx_ready = 1'b0;
        send_rx_pkt($urandom(), LOCAL_A, 8'h00);
        send_tx($urandom(), 2'd2);
        put_flit({6'h3F, LOCAL_A});
        put_flit(8'h11);
        put_flit(8'h22);
        rst_n = 1'b0;
        tick();
        check("t6_fo_valid", 32'(flit_out_valid), 32'd0);
        check("t6_tx_ready", 32'(tx_ready), 32'd1);
        check("t6_rx_valid", 32'(rx_valid), 32'd0);
        check("t6_flit_out", 32'(flit_out), 32'd0);
        rst_n    = 1'b1;
        rx_ready = 1'b1;
        tick();
        send_tx(32'hA5C3_0F96, 2'd1);
        send_rx_pkt(32'hCAFE_F00D, LOCAL_A, 8'h00);
        drain();

        // Random mix of traffic with random back-pressure on both sides.
        fo_mode = 2;
        rr_mode = 2;
        for (int n = 0; n < 24; n++) begin
            send_tx($urandom(), 2'($urandom_range(0, 3)));
            kind = int'($urandom_range(0, 3));
            w    = $urandom();
            if (kind == 0) begin
                send_rx_pkt(w, LOCAL_A, 8'h00);
            end else if (kind == 1) begin
                a = 2'($urandom_range(0, 2));
                if (a == LOCAL_A) a = 2'd3;
                send_rx_pkt(w, a, 8'h00);
            end else if (kind == 2) begin
                send_rx_pkt(w, LOCAL_A, 8'($urandom_range(1, 255)));
            end else begin
                put_flit(8'($urandom_range(0, 251)));
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
